mem_copy_engine: RTL and testbench

MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

---
 rtl/mem_copy_engine.sv | 144 ++++++++++++++
 tb/tb_mem_copy_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_engine.sv
// ---------------------------------------------------------------------------
// mem_copy_engine
//   Two small register-file memories, A and B, and a word-by-word copy engine
//   that moves a block of words from A into B.
//   The host writes and reads A, and it reads B. The copy engine is the only
//   agent that writes B.
//
// Ports
//   clock, reset          single clock; synchronous active-high reset
//   AddrA/WEA/DataInA     host port for A. WEA=1 writes; the write is dropped
//                         while busy.
//   DOut1                 registered A read data. It holds on write cycles.
//   AddrB/DOutB           host read port for B, registered, and always live
//   start                 one-cycle copy request, taken only in IDLE
//   src_base/dst_base/len copy descriptor, sampled with start.
//                         len is clamped to DEPTH.
//   busy                  high in RD/WR, so 2 cycles per word
//   done                  one-cycle pulse in FIN
// ---------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] AddrA,
  input  logic              WEA,
  input  logic [DATA_W-1:0] DataInA,
  output logic [DATA_W-1:0] DOut1,
  input  logic [ADDR_W-1:0] AddrB,
  output logic [DATA_W-1:0] DOutB,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2**ADDR_W;
  // DEPTH expressed in the len width. A one is followed by ADDR_W zeros.
  localparam logic [ADDR_W:0]   LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem_a [DEPTH];
  logic [DATA_W-1:0] r_mem_b [DEPTH];
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_hold;

  logic [ADDR_W:0]   w_len_clamped;
  logic              w_host_we;
  logic              w_copy_we;

  assign w_len_clamped = (len > LEN_MAX) ? LEN_MAX : len;
  // Host writes to A are dropped while a copy owns the memory.
  assign w_host_we     = WEA & ~busy;
  // Suppress the copy write on the edge that reset is sampled.
  // An aborted copy leaves no partial word behind.
  assign w_copy_we     = (r_state == WR) & ~reset;

  // Memory arrays carry no reset. Their contents survive reset.
  always_ff @(posedge clock) begin
    if (w_host_we) r_mem_a[AddrA] <= DataInA;
    if (w_copy_we) r_mem_b[r_dst] <= r_hold;
  end

  // Host read ports
  always_ff @(posedge clock) begin
    if (reset) begin
      DOut1 <= '0;
      DOutB <= '0;
    end else begin
      if (!WEA) DOut1 <= r_mem_a[AddrA];
      DOutB <= r_mem_b[AddrB];
    end
  end

  // Copy FSM. busy and done are registered alongside the state.
  // Both therefore line up exactly with RD/WR and FIN.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (w_len_clamped != '0) begin
              r_src   <= src_base;
              r_dst   <= dst_base;
              r_cnt   <= w_len_clamped;
              busy    <= 1'b1;
              r_state <= RD;
            end else begin
              // An empty copy still reports completion.
              done    <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        RD: begin
          r_hold  <= r_mem_a[r_src];
          r_state <= WR;
        end
        WR: begin
          // Pointers wrap naturally at ADDR_W bits.
          r_src <= r_src + PTR_ONE;
          r_dst <= r_dst + PTR_ONE;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= FIN;
          end else begin
            r_state <= RD;
          end
        end
        FIN: begin
          // start is deliberately ignored here.
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;
  localparam int DEPTH = 8;

  logic       clock;
  logic       reset;
  logic [2:0] AddrA;
  logic       WEA;
  logic [7:0] DataInA;
  logic [7:0] DOut1;
  logic [2:0] AddrB;
  logic [7:0] DOutB;
  logic       start;
  logic [2:0] src_base;
  logic [2:0] dst_base;
  logic [3:0] len;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  // Reference contents of both memories
  logic [7:0] ma [DEPTH];
  logic [7:0] mb [DEPTH];

  mem_copy_engine #(.DATA_W(8), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset),
    .AddrA(AddrA), .WEA(WEA), .DataInA(DataInA), .DOut1(DOut1),
    .AddrB(AddrB), .DOutB(DOutB),
    .start(start), .src_base(src_base), .dst_base(dst_base), .len(len),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_a(input int a, input logic [7:0] v);
    AddrA = 3'(a); DataInA = v; WEA = 1'b1;
    step();
    WEA = 1'b0;
    ma[a] = v;
  endtask

  task automatic read_a(input int a);
    AddrA = 3'(a); WEA = 1'b0;
    step();
    check($sformatf("dout1_a%0d", a), 32'(DOut1), 32'(ma[a]));
  endtask

  task automatic sweep_b(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      AddrB = 3'(a);
      step();
      check($sformatf("%s_b%0d", tag, a), 32'(DOutB), 32'(mb[a]));
    end
  endtask

  // Run one copy. The model moves min(len,DEPTH) words with wrapping
  // addresses, and expects busy for 2N cycles and done on cycle 2N+1.
  // In disturb mode the task also does the following:
  //   - random host reads of A, each checked one cycle later;
  //   - one dropped write of 55 to A[3];
  //   - a second start while busy, which must be ignored;
  //   - a start issued in FIN, which must also be ignored.
  task automatic do_copy(input int s, input int d, input int l, input bit disturb);
    int n, busy_cyc, done_cyc, cyc, pend;
    n = (l > DEPTH) ? DEPTH : l;
    for (int i = 0; i < n; i++) mb[(d + i) % DEPTH] = ma[(s + i) % DEPTH];
    src_base = 3'(s); dst_base = 3'(d); len = 4'(l); start = 1'b1;
    step();
    start = 1'b0;
    busy_cyc = 0; done_cyc = -1; cyc = 0; pend = -1;
    while (done_cyc < 0 && cyc < 100) begin
      cyc++;
      if (busy) busy_cyc++;
      if (done) done_cyc = cyc;
      if (disturb && pend >= 0) check("dout1_during_copy", 32'(DOut1), 32'(ma[pend]));
      if (done_cyc < 0) begin
        if (disturb) begin
          start = (cyc == 3);
          if (cyc == 3) begin src_base = 3'd1; dst_base = 3'd5; len = 4'd2; end
          if (cyc == 5) begin
            WEA = 1'b1; AddrA = 3'd3; DataInA = 8'h55;   // must be dropped
          end else begin
            WEA = 1'b0; AddrA = 3'($urandom_range(0, 7)); pend = int'(AddrA);
          end
        end
        step();
      end
    end
    WEA = 1'b0; start = 1'b0;
    check("busy_cycles", 32'(busy_cyc), 32'(2 * n));
    check("done_cycle", 32'(done_cyc), 32'(2 * n + 1));
    if (disturb) begin
      start = 1'b1; src_base = 3'd2; dst_base = 3'd2; len = 4'd3;
    end
    step();
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    step();
    check("idle_after_fin", 32'({busy, done}), 32'd0);
    sweep_b("copy");
  endtask

  // Abort a copy by asserting reset during cycle k (1..2N).
  // Only the WR cycles that completed before cycle k leave words in B.
  task automatic reset_copy(input int s, input int d, input int l, input int k);
    int n, w, dn;
    n = (l > DEPTH) ? DEPTH : l;
    w = (k - 1) / 2;
    if (w > n) w = n;
    for (int i = 0; i < w; i++) mb[(d + i) % DEPTH] = ma[(s + i) % DEPTH];
    src_base = 3'(s); dst_base = 3'(d); len = 4'(l); start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < k; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_dout1", 32'(DOut1), 32'd0);
    check("abort_doutb", 32'(DOutB), 32'd0);
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      dn += int'(done) + int'(busy);
    end
    check("abort_quiet", 32'(dn), 32'd0);
    sweep_b("abort");
  endtask

  initial begin
    logic [7:0] pat [DEPTH];
    int s, d, l, k;
    pat = '{8'hFF, 8'h00, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    for (int i = 0; i < DEPTH; i++) begin ma[i] = '0; mb[i] = '0; end

    reset = 1'b1; AddrA = '0; WEA = 1'b0; DataInA = '0; AddrB = '0;
    start = 1'b0; src_base = '0; dst_base = '0; len = '0;
    step(); step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout1", 32'(DOut1), 32'd0);
    check("rst_doutb", 32'(DOutB), 32'd0);
    reset = 1'b0;

    // Load A with the reference pattern, then read it back.
    for (int i = 0; i < DEPTH; i++) write_a(i, pat[i]);
    for (int i = 0; i < DEPTH; i++) read_a(i);

    // DOut1 holds on a write cycle.
    read_a(5);
    write_a(6, ma[6]);
    check("dout1_hold_on_write", 32'(DOut1), 32'(ma[5]));

    do_copy(0, 0, 8, 1'b0);   // full copy
    do_copy(6, 7, 3, 1'b0);   // wrapping source and destination
    do_copy(0, 3, 0, 1'b0);   // empty copy
    do_copy(0, 0, 8, 1'b1);   // disturbed copy
    read_a(3);                // 04 must have survived the dropped write

    // Clear B through the engine, restore A, then abort a copy in cycle 5.
    for (int i = 0; i < DEPTH; i++) write_a(i, 8'h00);
    do_copy(0, 0, 8, 1'b0);
    for (int i = 0; i < DEPTH; i++) write_a(i, pat[i]);
    reset_copy(0, 0, 8, 5);

    do_copy(2, 5, 12, 1'b0);  // len is clamped to DEPTH

    // Randomized copies against the model
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < 3; j++) write_a($urandom_range(0, 7), 8'($urandom));
      s = $urandom_range(0, 7); d = $urandom_range(0, 7); l = $urandom_range(0, 15);
      do_copy(s, d, l, it[0]);
    end
    for (int it = 0; it < 2; it++) begin
      s = $urandom_range(0, 7); d = $urandom_range(0, 7); l = $urandom_range(1, 8);
      k = $urandom_range(1, 2 * l);
      reset_copy(s, d, l, k);
    end
    for (int i = 0; i < DEPTH; i++) read_a(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
